// File: rtl/nand_vector_checker.sv
// ---------------------------------------------------------------------------
// nand_vector_checker
//
// Exhaustive self-checking harness stage for a set of parallel NAND
// implementations that all see the same input vector.
//
//  - Stimulus half: walks o_stim through every one of the 2^N_IN input
//    combinations. Each vector is driven, given SETTLE wait cycles, and then
//    checked.
//  - Checking half: compares every implementation output against the golden
//    value ~&stim. It counts mismatching vectors (saturating), captures the
//    first failing vector with its per-implementation mask, and raises a
//    pass flag at the end of the sweep.
//
// Parameters
//   N_IN    NAND fan-in / stim width (>= 2)
//   N_IMPL  number of implementation outputs compared (>= 1)
//   SETTLE  wait cycles between driving stim and sampling i_dut_y (>= 0)
//   ERR_W   width of the saturating error counter
//
// Ports
//   clk                in   rising-edge clock
//   rst_n              in   asynchronous active-low reset
//   i_start            in   begin a sweep (only looked at while idle)
//   i_dut_y            in   implementation outputs, bit i = implementation i
//   o_stim             out  registered vector fed to every implementation
//   o_busy             out  high while a sweep is in progress
//   o_done             out  one-cycle pulse at the end of a sweep
//   o_pass             out  no mismatches in the sweep; valid from o_done on
//   o_err_count        out  number of mismatching vectors, saturating
//   o_fail_valid       out  a mismatch has been captured this sweep
//   o_first_fail_vec   out  stim value of the first mismatching vector
//   o_first_fail_mask  out  per-implementation mismatch bits at that vector
// ---------------------------------------------------------------------------
module nand_vector_checker #(
  parameter int N_IN   = 2,
  parameter int N_IMPL = 3,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [N_IMPL-1:0] i_dut_y,
  output logic [N_IN-1:0]   o_stim,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ERR_W-1:0]  o_err_count,
  output logic              o_fail_valid,
  output logic [N_IN-1:0]   o_first_fail_vec,
  output logic [N_IMPL-1:0] o_first_fail_mask
);

  // The settle counter needs at least one bit even when SETTLE is 0 and the
  // WAIT state is never entered.
  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [N_IN-1:0]     r_vec;        // next vector to apply
  logic [CNT_W-1:0]    r_settle;     // remaining wait cycles
  logic [N_IN-1:0]     r_stim;
  logic                r_pass;
  logic [ERR_W-1:0]    r_err_count;
  logic                r_fail_valid;
  logic [N_IN-1:0]     r_first_fail_vec;
  logic [N_IMPL-1:0]   r_first_fail_mask;

  logic                w_exp;        // golden NAND of the applied vector
  logic [N_IMPL-1:0]   w_mism;       // per-implementation mismatch
  logic                w_mism_any;
  logic                w_last_vec;
  logic                w_settle_last;
  logic [ERR_W-1:0]    w_err_inc;    // saturating increment
  logic [ERR_W-1:0]    w_err_next;   // count including this CHECK

  // -------------------------------------------------------------------------
  // Compare logic
  // -------------------------------------------------------------------------
  assign w_exp = ~&r_stim;

  // Case inequality so an X or Z on an implementation output is reported as
  // a mismatch in simulation; it reduces to an ordinary XOR in hardware.
  for (genvar g = 0; g < N_IMPL; g++) begin : g_mism
    assign w_mism[g] = (i_dut_y[g] !== w_exp);
  end

  assign w_mism_any    = |w_mism;
  assign w_last_vec    = (r_vec == {N_IN{1'b1}});
  assign w_settle_last = (r_settle <= CNT_W'(1));
  assign w_err_inc     = (r_err_count == {ERR_W{1'b1}}) ? r_err_count
                                                        : r_err_count + ERR_W'(1);
  assign w_err_next    = w_mism_any ? w_err_inc : r_err_count;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment before the case keeps every path driven, so
  // no latch is inferred for w_state_next.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_APPLY;
        end
      end
      S_APPLY: begin
        w_state_next = (SETTLE == 0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        // Leave in the cycle the counter steps down to zero.
        if (w_settle_last) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_next = w_last_vec ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: vector sequencing, settle counter and result capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec             <= '0;
      r_settle          <= '0;
      r_stim            <= '0;
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_fail_valid      <= 1'b0;
      r_first_fail_vec  <= '0;
      r_first_fail_mask <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Results of the previous sweep stay visible until a new start.
          if (i_start) begin
            r_vec             <= '0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_fail_valid      <= 1'b0;
            r_first_fail_vec  <= '0;
            r_first_fail_mask <= '0;
          end
        end
        S_APPLY: begin
          r_stim   <= r_vec;
          r_settle <= CNT_W'(SETTLE);
        end
        S_WAIT: begin
          r_settle <= r_settle - CNT_W'(1);
        end
        S_CHECK: begin
          r_err_count <= w_err_next;
          if (w_mism_any && !r_fail_valid) begin
            r_fail_valid      <= 1'b1;
            r_first_fail_vec  <= r_stim;
            r_first_fail_mask <= w_mism;
          end
          if (w_last_vec) begin
            // Settled on entry to DONE, so pass is already valid alongside
            // the done pulse and includes this final comparison.
            r_pass <= (w_err_next == '0);
          end else begin
            r_vec <= r_vec + N_IN'(1);
          end
        end
        default: begin
          // S_DONE: everything holds.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_stim            = r_stim;
  assign o_busy            = (r_state == S_APPLY) || (r_state == S_WAIT) ||
                             (r_state == S_CHECK);
  assign o_done            = (r_state == S_DONE);
  assign o_pass            = r_pass;
  assign o_err_count       = r_err_count;
  assign o_fail_valid      = r_fail_valid;
  assign o_first_fail_vec  = r_first_fail_vec;
  assign o_first_fail_mask = r_first_fail_mask;

endmodule

// File: tb/tb_nand_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_nand_vector_checker
//
// Directed bench for nand_vector_checker. Three instances share clk/rst_n:
//   u_dut_def : default parameters, implementation outputs selectable
//               between correct and implementation 1 stuck-at-0
//   u_dut_e2  : ERR_W=2, all implementations inverted
//   u_dut_n3  : N_IN=3, SETTLE=0, correct implementations
// Cycle k is the interval after clock edge k-1, where edge 0 is the edge
// that samples start; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_nand_vector_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] r_start = '0;
  int   mode0 = 0;           // 0: correct, 1: impl1 stuck-at-0
  int   r_sel = 0;           // which instance the observer looks at

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // ---- instance 0: defaults ----
  logic [1:0] stim0;
  logic [2:0] y0, ffm0;
  logic       busy0, done0, pass0, fv0;
  logic [7:0] err0;
  logic [1:0] ffv0;
  assign y0 = (mode0 == 1) ? ({3{~&stim0}} & 3'b101) : {3{~&stim0}};

  nand_vector_checker u_dut_def (
    .clk(clk), .rst_n(rst_n), .i_start(r_start[0]), .i_dut_y(y0),
    .o_stim(stim0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_count(err0), .o_fail_valid(fv0),
    .o_first_fail_vec(ffv0), .o_first_fail_mask(ffm0)
  );

  // ---- instance 1: ERR_W=2, inverted implementations ----
  logic [1:0] stim1;
  logic [2:0] y1, ffm1;
  logic       busy1, done1, pass1, fv1;
  logic [1:0] err1;
  logic [1:0] ffv1;
  assign y1 = {3{&stim1}};

  nand_vector_checker #(.ERR_W(2)) u_dut_e2 (
    .clk(clk), .rst_n(rst_n), .i_start(r_start[1]), .i_dut_y(y1),
    .o_stim(stim1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_count(err1), .o_fail_valid(fv1),
    .o_first_fail_vec(ffv1), .o_first_fail_mask(ffm1)
  );

  // ---- instance 2: N_IN=3, SETTLE=0, correct implementations ----
  logic [2:0] stim2;
  logic [2:0] y2, ffm2;
  logic       busy2, done2, pass2, fv2;
  logic [7:0] err2;
  logic [2:0] ffv2;
  assign y2 = {3{~&stim2}};

  nand_vector_checker #(.N_IN(3), .SETTLE(0)) u_dut_n3 (
    .clk(clk), .rst_n(rst_n), .i_start(r_start[2]), .i_dut_y(y2),
    .o_stim(stim2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_count(err2), .o_fail_valid(fv2),
    .o_first_fail_vec(ffv2), .o_first_fail_mask(ffm2)
  );

  // ---- observer: selected instance widened to 32 bits ----
  logic [31:0] ob_stim, ob_busy, ob_done, ob_pass, ob_err, ob_fv, ob_ffv, ob_ffm;
  always_comb begin
    ob_stim = '0; ob_busy = '0; ob_done = '0; ob_pass = '0;
    ob_err  = '0; ob_fv   = '0; ob_ffv  = '0; ob_ffm  = '0;
    case (r_sel)
      1: begin
        ob_stim = 32'(stim1); ob_busy = 32'(busy1); ob_done = 32'(done1);
        ob_pass = 32'(pass1); ob_err  = 32'(err1);  ob_fv   = 32'(fv1);
        ob_ffv  = 32'(ffv1);  ob_ffm  = 32'(ffm1);
      end
      2: begin
        ob_stim = 32'(stim2); ob_busy = 32'(busy2); ob_done = 32'(done2);
        ob_pass = 32'(pass2); ob_err  = 32'(err2);  ob_fv   = 32'(fv2);
        ob_ffv  = 32'(ffv2);  ob_ffm  = 32'(ffm2);
      end
      default: begin
        ob_stim = 32'(stim0); ob_busy = 32'(busy0); ob_done = 32'(done0);
        ob_pass = 32'(pass0); ob_err  = 32'(err0);  ob_fv   = 32'(fv0);
        ob_ffv  = 32'(ffv0);  ob_ffm  = 32'(ffm0);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All outputs of the observed instance packed together (zero after reset).
  function automatic logic [31:0] all_outs();
    return ob_stim | ob_busy | ob_done | ob_pass | ob_err | ob_fv | ob_ffv | ob_ffm;
  endfunction

  // Start a sweep on instance sel and watch it for budget cycles. Checks
  // stim at every CHECK cycle (i+1)*(settle+2) and records done timing.
  task automatic sweep(input int sel, input int n_vecs, input int settle,
                       input int budget, input bit repulse, input bit hold,
                       output int done_cyc, output int n_done, output logic done_pass);
    r_sel     = sel;
    done_cyc  = -1;
    n_done    = 0;
    done_pass = 1'b0;
    @(negedge clk);
    r_start[sel] = 1'b1;
    @(posedge clk);                       // edge 0
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (!hold) r_start[sel] = repulse && (cyc == 3 || cyc == 9);
      if (ob_done[0]) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc  = cyc;
          done_pass = ob_pass[0];
        end
      end
      if (cyc % (settle + 2) == 0 && cyc / (settle + 2) <= n_vecs)
        check($sformatf("stim_c%0d_s%0d", cyc, sel), ob_stim,
              32'(cyc / (settle + 2) - 1));
    end
  endtask

  initial begin
    int       dc, nd;
    logic     dp;
    bit       seen;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    r_sel = 0; #1 check("rst_outs_def", all_outs(), 0);
    r_sel = 1; #1 check("rst_outs_e2",  all_outs(), 0);
    r_sel = 2; #1 check("rst_outs_n3",  all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- T1: correct implementations ----
    mode0 = 0;
    sweep(0, 4, 1, 16, 1'b0, 1'b0, dc, nd, dp);
    check("t1_done_cyc",  32'(dc), 13);
    check("t1_n_done",    32'(nd), 1);
    check("t1_pass_at_done", 32'(dp), 1);
    check("t1_pass",      ob_pass, 1);
    check("t1_err",       ob_err, 0);
    check("t1_fail_valid", ob_fv, 0);
    check("t1_stim_held", ob_stim, 3);
    check("t1_busy_idle", ob_busy, 0);

    // ---- T2: implementation 1 stuck-at-0 ----
    mode0 = 1;
    sweep(0, 4, 1, 16, 1'b0, 1'b0, dc, nd, dp);
    check("t2_done_cyc",  32'(dc), 13);
    check("t2_pass_at_done", 32'(dp), 0);
    check("t2_err",       ob_err, 3);
    check("t2_fail_valid", ob_fv, 1);
    check("t2_ffv",       ob_ffv, 0);
    check("t2_ffm",       ob_ffm, 3'b010);
    check("t2_pass",      ob_pass, 0);

    // ---- T3: start re-pulsed mid-sweep is ignored ----
    mode0 = 0;
    sweep(0, 4, 1, 20, 1'b1, 1'b0, dc, nd, dp);
    check("t3_done_cyc",  32'(dc), 13);
    check("t3_n_done",    32'(nd), 1);
    check("t3_err",       ob_err, 0);
    check("t3_pass",      ob_pass, 1);
    check("t3_ffm_clear", ob_ffm, 0);

    // ---- T4: reset at cycle 6 mid-sweep ----
    mode0 = 1;
    r_sel = 0;
    @(negedge clk);
    r_start[0] = 1'b1;
    @(posedge clk);                       // edge 0
    @(negedge clk);                       // cycle 1
    r_start[0] = 1'b0;
    repeat (4) @(negedge clk);            // cycle 5
    check("t4_err_before_rst", ob_err, 1);
    @(negedge clk);                       // cycle 6
    rst_n = 1'b0;
    #1 check("t4_outs_zero", all_outs(), 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ob_done[0]) seen = 1'b1;
    end
    check("t4_no_done", 32'(seen), 0);
    rst_n = 1'b1;
    mode0 = 0;
    @(negedge clk);
    sweep(0, 4, 1, 16, 1'b0, 1'b0, dc, nd, dp);
    check("t4_done_cyc",  32'(dc), 13);
    check("t4_pass",      ob_pass, 1);
    check("t4_err",       ob_err, 0);

    // ---- T5: ERR_W=2, every vector mismatches, count saturates ----
    sweep(1, 4, 1, 16, 1'b0, 1'b0, dc, nd, dp);
    check("t5_done_cyc",  32'(dc), 13);
    check("t5_err_sat",   ob_err, 3);
    check("t5_pass",      ob_pass, 0);
    check("t5_fail_valid", ob_fv, 1);
    check("t5_ffv",       ob_ffv, 0);
    check("t5_ffm",       ob_ffm, 3'b111);

    // ---- T6: N_IN=3, SETTLE=0, start held high ----
    sweep(2, 8, 0, 18, 1'b0, 1'b1, dc, nd, dp);
    check("t6_done_cyc",  32'(dc), 17);
    check("t6_n_done",    32'(nd), 1);
    check("t6_pass_at_done", 32'(dp), 1);
    check("t6_idle_c18",  ob_busy, 0);
    @(negedge clk);                       // cycle 19
    check("t6_busy_c19",  ob_busy, 1);
    r_start[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (ob_done[0]) seen = 1'b1;
    end
    check("t6_second_done", 32'(seen), 1);
    check("t6_second_pass", ob_pass, 1);
    check("t6_second_err",  ob_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
